scc_mem_arbiter: RTL
====================

Name: scc_mem_arbiter

Overview:
Single-port memory arbiter/sequencer for the SCC core. Shares one memory port between the instruction-fetch requester and the data (load/store) requester. Uses a req/gnt/rvalid handshake and a fixed, parameterised read latency. Sits between the IF/EX stages and the external memory port, and drives the memory enable, address, write-data and write-enable.

Parameters:
ADDR_W, 32, address width of requesters and memory port
DATA_W, 32, data width
MEM_LAT, 2, cycles from the mem_en cycle to mem_rdata valid; legal range 1..15 (4-bit counter)

Ports:
clk        in   1       main clock; all flops rise-edge
reset      in   1       asynchronous, active-high; forces known state
if_req     in   1       fetch read request; hold with if_addr until if_gnt
if_addr    in   ADDR_W  fetch address
if_gnt     out  1       one-cycle pulse: fetch request issued to memory
if_rvalid  out  1       one-cycle pulse: if_rdata valid
if_rdata   out  DATA_W  fetched instruction word
d_req      in   1       data request; hold d_we/d_addr/d_wdata until d_gnt
d_we       in   1       1 = write, 0 = read
d_addr     in   ADDR_W  data address
d_wdata    in   DATA_W  store data
d_gnt      out  1       one-cycle pulse: data request issued
d_rvalid   out  1       one-cycle pulse: d_rdata valid (reads only)
d_rdata    out  DATA_W  load data
mem_en     out  1       memory access strobe
mem_we     out  1       memory write enable
mem_addr   out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in   DATA_W  memory read data

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - All outputs go to 0, including rdata regs, counter and mem_* outputs.
  - An in-flight transaction is dropped silently: no gnt or rvalid after reset releases. Requesters must reissue.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If d_req or if_req is sampled high, select a winner per the priority rules, latch its address/we/wdata and owner, and go to ISSUE.
  - If neither is high, stay in IDLE.
- ISSUE (one cycle, call it T):
  - mem_en=1; mem_we = latched we (fetch always 0); mem_addr/mem_wdata = latched values.
  - The owner's gnt=1.
  - Write: go to IDLE.
  - Read: load counter with MEM_LAT and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle where counter==1 (cycle T+MEM_LAT), capture mem_rdata into the owner's rdata reg and go to RESP.
- RESP (cycle T+MEM_LAT+1): the owner's rvalid=1, then go to IDLE.
- Outside ISSUE: mem_en, mem_we, mem_addr and mem_wdata are 0.
- x_rdata holds its last captured value between rvalids. The non-owner's rdata is never modified.
- Latency:
  - Request seen in IDLE at cycle C gives gnt at C+1.
  - Read: rvalid at C+MEM_LAT+2. Minimum read spacing is MEM_LAT+3 cycles.
  - Write: one write per 2 cycles.
- Requests are sampled only in IDLE. A req deasserted before gnt is a withdrawal: no access, no side effects.
- Priority, default: data beats fetch when both request in the same IDLE cycle. Fetch starvation under continuous d_req is accepted.
- gnt and rvalid are never asserted for both requesters in the same cycle. At most one transaction is outstanding.
- Fetch requests never write, regardless of any other input.

Optional Feature:
SCC_ARB_RR_EN
- Defined:
  - A last_owner flop (reset = fetch) records the owner of every ISSUE.
  - When both requesters contend in IDLE, the one that was NOT last_owner wins. The first contest after reset goes to data; grants then alternate while both are held.
  - Single requester: granted as normal.
- Undefined: fixed data priority; no last_owner flop.

Test Plan:
- MEM_LAT=2. if_req=1, if_addr=0x0000_0010 in IDLE at C; memory returns 0xDEADBEEF at C+3:
  - C+1: if_gnt=1, mem_en=1, mem_we=0, mem_addr=0x10.
  - C+4: if_rvalid=1, if_rdata=0xDEADBEEF.
- Write: d_req=1, d_we=1, d_addr=0x200, d_wdata=0x1234 at C:
  - C+1: mem_en=mem_we=1, mem_addr=0x200, mem_wdata=0x1234, d_gnt=1.
  - d_rvalid never asserts; IDLE at C+2.
- Both requesters reading and held continuously at C, macro undefined:
  - d_gnt at C+1, d_rvalid at C+4, if_gnt at C+6.
  - With SCC_ARB_RR_EN and requests re-raised: subsequent grants alternate data, fetch, data, fetch.
- reset pulsed high at C+2 during a read WAIT:
  - All outputs go to 0 in the same cycle.
  - After release with no req: no rvalid, no mem_en for 10 cycles.
- if_req high for one cycle only, while a data read is in WAIT: no if_gnt and no fetch mem_en ever occurs.
- MEM_LAT=1, if_req held with changing addresses 0x0, 0x4: gnts exactly 4 cycles apart; rdata matches mem_rdata captured at T+1.

Source files
------------

// File: rtl/scc_mem_arbiter_if.sv
// scc_mem_arbiter_if: requester and memory-port signals of the SCC memory
// arbiter. The slave modport is the arbiter's view; master is the view of
// the surrounding fetch/data requesters and the memory.
interface scc_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // Data requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // Memory port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/scc_mem_arbiter.sv
// scc_mem_arbiter: shares one fixed-latency memory port between the
// instruction-fetch and data requesters. One transaction in flight at a time;
// all outputs are registered. Data has fixed priority over fetch unless
// SCC_ARB_RR_EN is defined, which alternates grants under contention.
module scc_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input logic             clk,
    input logic             reset,
    scc_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic              own_d, own_d_nx;      // 1 = data owns the transaction
    logic              lat_we, lat_we_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              pick_d;
    logic              prefer_d;

    logic              if_gnt_q, if_gnt_nx;
    logic              d_gnt_q, d_gnt_nx;
    logic              if_rvalid_q, if_rvalid_nx;
    logic              d_rvalid_q, d_rvalid_nx;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_nx;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_nx;
    logic              mem_en_q, mem_en_nx;
    logic              mem_we_q, mem_we_nx;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_nx;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nx;

`ifdef SCC_ARB_RR_EN
    logic last_own_d;

    // Remember who owned the most recent issued access
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_own_d <= 1'b0;
        else if (state == ISSUE)
            last_own_d <= own_d;
    end

    assign prefer_d = ~last_own_d;
`else
    assign prefer_d = 1'b1;
`endif

    // Next-state and next-output logic; outputs are computed one cycle
    // ahead so that every port is driven straight from a flop
    always_comb begin
        state_nx     = state;
        own_d_nx     = own_d;
        lat_we_nx    = lat_we;
        cnt_nx       = cnt;
        pick_d       = 1'b0;
        if_gnt_nx    = 1'b0;
        d_gnt_nx     = 1'b0;
        if_rvalid_nx = 1'b0;
        d_rvalid_nx  = 1'b0;
        if_rdata_nx  = if_rdata_q;
        d_rdata_nx   = d_rdata_q;
        mem_en_nx    = 1'b0;
        mem_we_nx    = 1'b0;
        mem_addr_nx  = '0;
        mem_wdata_nx = '0;

        case (state)
            IDLE: begin
                if (bus.d_req || bus.if_req) begin
                    pick_d       = bus.d_req && (!bus.if_req || prefer_d);
                    own_d_nx     = pick_d;
                    lat_we_nx    = pick_d && bus.d_we;
                    mem_en_nx    = 1'b1;
                    mem_we_nx    = pick_d && bus.d_we;
                    mem_addr_nx  = pick_d ? bus.d_addr : bus.if_addr;
                    mem_wdata_nx = pick_d ? bus.d_wdata : '0;
                    d_gnt_nx     = pick_d;
                    if_gnt_nx    = !pick_d;
                    state_nx     = ISSUE;
                end
            end
            ISSUE: begin
                if (lat_we) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx   = 4'(MEM_LAT);
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    if (own_d) begin
                        d_rdata_nx  = bus.mem_rdata;
                        d_rvalid_nx = 1'b1;
                    end else begin
                        if_rdata_nx  = bus.mem_rdata;
                        if_rvalid_nx = 1'b1;
                    end
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, transaction context and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            own_d       <= 1'b0;
            lat_we      <= 1'b0;
            cnt         <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state       <= state_nx;
            own_d       <= own_d_nx;
            lat_we      <= lat_we_nx;
            cnt         <= cnt_nx;
            if_gnt_q    <= if_gnt_nx;
            d_gnt_q     <= d_gnt_nx;
            if_rvalid_q <= if_rvalid_nx;
            d_rvalid_q  <= d_rvalid_nx;
            if_rdata_q  <= if_rdata_nx;
            d_rdata_q   <= d_rdata_nx;
            mem_en_q    <= mem_en_nx;
            mem_we_q    <= mem_we_nx;
            mem_addr_q  <= mem_addr_nx;
            mem_wdata_q <= mem_wdata_nx;
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
